// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl: session controller feeding the decrypt pipeline through a credit-guarded output FIFO.
// Define DECRYPT_CTRL_ABORT_EN to add the abort input and FLUSH state.
module decrypt_ctrl #(
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
`ifdef DECRYPT_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             pipe_en,
  output logic [7:0]       pipe_din,
  output logic [7:0]       pipe_k1,
  output logic [7:0]       pipe_k2,
  output logic [7:0]       pipe_k3,
  output logic [2:0]       pipe_rot_freq,
  output logic             pipe_shift_en,
  output logic [2:0]       pipe_shift_amt,
  output logic             pipe_mode,
  output logic [2:0]       pipe_perm0,
  output logic [2:0]       pipe_perm1,
  output logic [2:0]       pipe_perm2,
  output logic [2:0]       pipe_perm3,
  output logic [2:0]       pipe_perm4,
  output logic [2:0]       pipe_perm5,
  output logic [2:0]       pipe_perm6,
  output logic [2:0]       pipe_perm7,
  input  logic             pipe_v,
  input  logic [7:0]       pipe_dout,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef DECRYPT_CTRL_ABORT_EN
  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, FLUSH} state_t;
`else
  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN} state_t;
`endif
  state_t           state;
  logic [LEN_W-1:0] rem_in, rem_out;
  logic [CW-1:0]    inflight, count;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [7:0]       k1, k2, k3, ctl;
  logic [2:0]       perm [8];
  logic [7:0]       seen;
  logic             perm_ok, hs, dec, push, pop, flushing, abort_hit;

`ifdef DECRYPT_CTRL_ABORT_EN
  assign abort_hit = abort && (state == RUN || state == DRAIN);
  assign flushing  = state == FLUSH;
`else
  assign abort_hit = 1'b0;
  assign flushing  = 1'b0;
`endif

  always_comb begin
    seen = '0;
    for (int i = 0; i < 8; i++) seen[perm[i]] = 1'b1;
    perm_ok = &seen;
  end

  // Credit check: bytes in the pipe plus bytes already queued may never exceed the FIFO.
  assign in_ready  = state == RUN && rem_in != '0 && !abort_hit &&
                     (CW+1)'(inflight) + (CW+1)'(count) < (CW+1)'(FIFO_DEPTH);
  assign hs        = in_valid && in_ready;
  assign pipe_en   = hs;
  assign pipe_din  = hs ? in_data : 8'h00;
  // Pulses with nothing in flight are stale leftovers from before a reset.
  assign dec       = pipe_v && inflight != '0;
  assign push      = dec && !flushing;
  assign out_valid = count != '0 && !flushing;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign busy      = state != IDLE;
  assign cfg_err   = state == CHECK && !perm_ok;
  assign done      = (state == CHECK && perm_ok && rem_in == '0) ||
                     (state == DRAIN && pop && rem_out == LEN_W'(1) && !abort_hit) ||
                     (flushing && inflight == '0);

  assign pipe_k1        = k1;
  assign pipe_k2        = k2;
  assign pipe_k3        = k3;
  assign pipe_mode      = ctl[7];
  assign pipe_shift_en  = ctl[6];
  assign pipe_shift_amt = ctl[5:3];
  assign pipe_rot_freq  = ctl[2:0];
  assign pipe_perm0     = perm[0];
  assign pipe_perm1     = perm[1];
  assign pipe_perm2     = perm[2];
  assign pipe_perm3     = perm[3];
  assign pipe_perm4     = perm[4];
  assign pipe_perm5     = perm[5];
  assign pipe_perm6     = perm[6];
  assign pipe_perm7     = perm[7];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= pipe_dout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rem_in   <= '0;
      rem_out  <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      k1       <= '0;
      k2       <= '0;
      k3       <= '0;
      ctl      <= '0;
      for (int i = 0; i < 8; i++) perm[i] <= 3'(i);
    end else begin
      if (cfg_we && state == IDLE) begin
        if (cfg_addr == 4'd0) k1 <= cfg_wdata;
        if (cfg_addr == 4'd1) k2 <= cfg_wdata;
        if (cfg_addr == 4'd2) k3 <= cfg_wdata;
        if (cfg_addr == 4'd3) ctl <= cfg_wdata;
        if (cfg_addr >= 4'd4 && cfg_addr <= 4'd11) perm[3'(cfg_addr - 4'd4)] <= cfg_wdata[2:0];
      end
      inflight <= inflight + CW'(hs) - CW'(dec);
      if (flushing) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (hs) rem_in <= rem_in - LEN_W'(1);
      if (pop) rem_out <= rem_out - LEN_W'(1);
      case (state)
        IDLE: if (start) begin
          state   <= CHECK;
          rem_in  <= msg_len;
          rem_out <= msg_len;
        end
        CHECK: state <= !perm_ok || rem_in == '0 ? IDLE : RUN;
`ifdef DECRYPT_CTRL_ABORT_EN
        RUN:   state <= abort_hit ? FLUSH : hs && rem_in == LEN_W'(1) ? DRAIN : RUN;
        DRAIN: state <= abort_hit ? FLUSH : done ? IDLE : DRAIN;
        FLUSH: state <= inflight == '0 ? IDLE : FLUSH;
`else
        RUN:   state <= hs && rem_in == LEN_W'(1) ? DRAIN : RUN;
        DRAIN: state <= done ? IDLE : DRAIN;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (rst) assert (FIFO_DEPTH >= PIPE_LAT && !(push && !pop && count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_decrypt_ctrl.sv
// tb_decrypt_ctrl: directed bench with a pipeline model and an output scoreboard for decrypt_ctrl.
// Exercises the abort path too when DECRYPT_CTRL_ABORT_EN is defined.
module tb_decrypt_ctrl;
  localparam int PIPE_LAT = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic cfg_we = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0, abort = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0, in_data = '0;
  logic [15:0] msg_len = '0;
  logic busy, done, cfg_err, in_ready, pipe_en, pipe_shift_en, pipe_mode, pipe_v, out_valid;
  logic [7:0] pipe_din, pipe_k1, pipe_k2, pipe_k3, pipe_dout, out_data;
  logic [2:0] pipe_rot_freq, pipe_shift_amt;
  logic [2:0] pipe_perm0, pipe_perm1, pipe_perm2, pipe_perm3, pipe_perm4, pipe_perm5, pipe_perm6, pipe_perm7;
  int vecs = 0, miscmp = 0, cyc = 0;
  int hs_n, pop_n, done_n, hs_first, hs_last, ov_first, pop_last, done_cyc, n;
  logic [7:0] ek1 = '0, ek2 = '0, ek3 = '0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  decrypt_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .msg_len(msg_len), .busy(busy), .done(done), .cfg_err(cfg_err),
`ifdef DECRYPT_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pipe_en(pipe_en), .pipe_din(pipe_din), .pipe_k1(pipe_k1), .pipe_k2(pipe_k2), .pipe_k3(pipe_k3),
    .pipe_rot_freq(pipe_rot_freq), .pipe_shift_en(pipe_shift_en), .pipe_shift_amt(pipe_shift_amt),
    .pipe_mode(pipe_mode), .pipe_perm0(pipe_perm0), .pipe_perm1(pipe_perm1), .pipe_perm2(pipe_perm2),
    .pipe_perm3(pipe_perm3), .pipe_perm4(pipe_perm4), .pipe_perm5(pipe_perm5), .pipe_perm6(pipe_perm6),
    .pipe_perm7(pipe_perm7), .pipe_v(pipe_v), .pipe_dout(pipe_dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  function automatic logic [7:0] f(input logic [7:0] b, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
    return ((b ^ a1) + a2) ^ a3;
  endfunction

  // Fixed-latency pipeline stand-in, keyed from the DUT's config outputs.
  logic [PIPE_LAT-1:0] v_sr = '0;
  logic [7:0] d_sr [PIPE_LAT];
  always @(posedge clk) begin
    v_sr <= {v_sr[PIPE_LAT-2:0], pipe_en};
    d_sr[0] <= f(pipe_din, pipe_k1, pipe_k2, pipe_k3);
    for (int i = 1; i < PIPE_LAT; i++) d_sr[i] <= d_sr[i-1];
  end
  assign pipe_v = v_sr[PIPE_LAT-1];
  assign pipe_dout = d_sr[PIPE_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes/pops at the falling edge, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      if (in_valid && in_ready) begin
        hs_n++;
        hs_last = cyc;
        if (hs_first < 0) hs_first = cyc;
        exp_q.push_back(f(in_data, ek1, ek2, ek3));
        chk("pipe_din", pipe_din, in_data);
      end
      if (out_valid && ov_first < 0) ov_first = cyc;
      if (out_valid && out_ready) begin
        pop_n++;
        pop_last = cyc;
        chk("sb_level", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
        if (!(out_valid && out_ready)) exp_q.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    hs_n = 0; pop_n = 0; done_n = 0; hs_first = -1; ov_first = -1; hs_last = -1; pop_last = -1; done_cyc = -1;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic begin_msg(input logic [15:0] len);
    clr();
    msg_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    n = 0;
    while (busy && n < lim) begin
      in_data = 8'($urandom);
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    clr();
    repeat (6) step();
    chk("rst_busy", busy, 0);
    chk("rst_flags", {done, cfg_err, in_ready, pipe_en, out_valid}, 0);
    chk("rst_pipe_din", pipe_din, 0);
    chk("rst_keys", {pipe_k1, pipe_k2, pipe_k3}, 0);
    chk("rst_perm", {pipe_perm7, pipe_perm6, pipe_perm5, pipe_perm4, pipe_perm3, pipe_perm2, pipe_perm1, pipe_perm0}, 24'o76543210);
    rst = 1'b1;
    step();

    cfg(4'd0, 8'h3C); cfg(4'd1, 8'hA5); cfg(4'd2, 8'h0F); cfg(4'd3, 8'hB5);
    ek1 = 8'h3C; ek2 = 8'hA5; ek3 = 8'h0F;
    for (int i = 0; i < 8; i++) cfg(4'(4 + i), 8'(7 - i));
    chk("cfg_keys", {pipe_k1, pipe_k2, pipe_k3}, 24'h3CA50F);
    chk("cfg_ctl", {pipe_mode, pipe_shift_en, pipe_shift_amt, pipe_rot_freq}, 8'hB5);
    chk("cfg_perm", {pipe_perm7, pipe_perm6, pipe_perm5, pipe_perm4, pipe_perm3, pipe_perm2, pipe_perm1, pipe_perm0}, 24'o01234567);

    out_ready = 1'b1; in_valid = 1'b1;
    begin_msg(16);
    chk("t1_check_busy", busy, 1);
    n = 0;
    while (busy && n < 200) begin
      in_data = 8'($urandom);
      start = n == 6;
      msg_len = n == 6 ? 16'd3 : 16'd16;
      step();
      n++;
    end
    start = 1'b0;
    chk("t1_idle", busy, 0);
    chk("t1_hs", hs_n, 16);
    chk("t1_b2b", hs_last - hs_first, 15);
    chk("t1_lat", ov_first - hs_first, PIPE_LAT + 1);
    chk("t1_pops", pop_n, 16);
    chk("t1_done_n", done_n, 1);
    chk("t1_done_pop", done_cyc, pop_last);
    chk("t1_busy_drop", cyc, done_cyc + 1);

    cfg(4'd4, 8'd2); cfg(4'd5, 8'd2);
    begin_msg(5);
    chk("t2_err", cfg_err, 1);
    chk("t2_busy", busy, 1);
    chk("t2_ir", in_ready, 0);
    step();
    chk("t2_err_end", cfg_err, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_hs", hs_n, 0);
    cfg(4'd4, 8'd7); cfg(4'd5, 8'd6);

    begin_msg(0);
    chk("t3_done", done, 1);
    chk("t3_pe", pipe_en, 0);
    step();
    chk("t3_busy", busy, 0);
    chk("t3_hs", hs_n + done_n, 1);

    out_ready = 1'b0;
    begin_msg(20);
    repeat (30) begin in_data = 8'($urandom); step(); end
    chk("t4_hs8", hs_n, 8);
    chk("t4_ir", in_ready, 0);
    chk("t4_ov", out_valid, 1);
    out_ready = 1'b1;
    wait_idle(200);
    chk("t4_pops", pop_n, 20);
    chk("t4_done", done_n, 1);
    chk("t4_sb", exp_q.size(), 0);

    in_valid = 1'b0;
    begin_msg(4);
    step();
    cfg(4'd0, 8'h77);
    chk("t5_k1_run", pipe_k1, 8'h3C);
    in_valid = 1'b1;
    wait_idle(100);
    chk("t5_pops", pop_n, 4);
    cfg(4'd0, 8'h77);
    ek1 = 8'h77;
    chk("t5_k1_idle", pipe_k1, 8'h77);
    begin_msg(3);
    wait_idle(100);
    chk("t5_pops2", pop_n, 3);

    begin_msg(10);
    repeat (4) begin in_data = 8'($urandom); step(); end
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    exp_q.delete();
    clr();
    repeat (8) begin
      step();
      chk("rm_ov", out_valid, 0);
    end
    chk("rm_busy", busy, 0);
    cfg(4'd0, 8'h3C); cfg(4'd1, 8'hA5); cfg(4'd2, 8'h0F);
    ek1 = 8'h3C;
    begin_msg(5);
    wait_idle(100);
    chk("rm_pops", pop_n, 5);

`ifdef DECRYPT_CTRL_ABORT_EN
    begin_msg(10);
    n = 0;
    while (hs_n < 5 && n < 50) begin in_data = 8'($urandom); step(); n++; end
    step();
    abort = 1'b1;
    chk("t6_ir_drop", in_ready, 0);
    step();
    abort = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      chk("t6_ov", out_valid, 0);
      chk("t6_ir", in_ready, 0);
      step();
      n++;
    end
    chk("t6_idle", busy, 0);
    chk("t6_hs", hs_n, 6);
    chk("t6_done", done_n, 1);
    begin_msg(4);
    wait_idle(100);
    chk("t6_clean_pops", pop_n, 4);
    chk("t6_clean_sb", exp_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
